id_ctrl_unit: RTL

Decode-stage control generator for the 5-stage SIMPLE pipeline. It decodes the 16-bit instruction held in IF/ID into the seven datapath switch controls and the register-write order, which the ID/EX register captures. It also owns the decode-side interlocks: a load-use stall bubble, a branch-flush window, and the HLT/restart state machine. Its outputs feed the ID/EX register directly. Its `stall` output freezes the PC and the IF/ID register.

---
 rtl/simple_pkg.sv | 39 +++
 rtl/id_decode.sv | 57 +++++
 rtl/id_ctrl_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE pipeline: opcode fields, decode constants
// and the decode-stage state encoding.
package simple_pkg;

    // Major opcode, instr[15:14]
    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ALU = 2'b11;

    // op3 field, instr[7:4], for the ALU/IO major opcode
    localparam logic [3:0] ALU_CMP = 4'd5;
    localparam logic [3:0] ALU_MAX = 4'd6;
    localparam logic [3:0] SHF_MIN = 4'd8;
    localparam logic [3:0] SHF_MAX = 4'd11;
    localparam logic [3:0] IO_IN   = 4'd12;
    localparam logic [3:0] IO_OUT  = 4'd13;
    localparam logic [3:0] SYS_HLT = 4'd15;

    // Branch-group sub-opcodes, instr[13:11]
    localparam logic [2:0] BR_LI  = 3'b000;
    localparam logic [2:0] BR_B   = 3'b100;
    localparam logic [2:0] BR_BCC = 3'b111;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    // LI, B and Bcc carry no source register in [13:11]/[10:8], so they
    // never take part in the load-use check.
    function automatic logic is_hazard_exempt(input logic [1:0] major,
                                              input logic [2:0] sub);
        return (major == OP_BR) &&
               ((sub == BR_LI) || (sub == BR_B) || (sub == BR_BCC));
    endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational instruction-to-control mapping for the decode stage.
// sw[0] = sw1 ... sw[6] = sw7. Reserved encodings and HLT decode to a bubble;
// is_hlt flags HLT so the caller can sequence into HALT.
module id_decode
    import simple_pkg::*;
(
    input  logic [1:0] major,
    input  logic [2:0] sub,
    input  logic [3:0] op3,
    output logic [6:0] sw,
    output logic       write_order,
    output logic       is_hlt
);

    // Field-based decode of the switch controls and register-write order
    always_comb begin
        sw          = '0;
        write_order = 1'b0;
        is_hlt      = 1'b0;
        case (major)
            OP_ALU: begin
                if (op3 <= ALU_MAX) begin
                    write_order = (op3 != ALU_CMP);
                end else if ((op3 >= SHF_MIN) && (op3 <= SHF_MAX)) begin
                    sw[5]       = 1'b1;
                    write_order = 1'b1;
                end else if (op3 == IO_IN) begin
                    write_order = 1'b1;
                end else if (op3 == IO_OUT) begin
                    sw[6] = 1'b1;
                end else if (op3 == SYS_HLT) begin
                    is_hlt = 1'b1;
                end
            end
            OP_LD: begin
                sw[0]       = 1'b1;
                sw[1]       = 1'b1;
                sw[3]       = 1'b1;
                write_order = 1'b1;
            end
            OP_ST: begin
                sw[0] = 1'b1;
                sw[2] = 1'b1;
            end
            default: begin
                if (sub == BR_LI) begin
                    sw[0]       = 1'b1;
                    write_order = 1'b1;
                end else if ((sub == BR_B) || (sub == BR_BCC)) begin
                    sw[0] = 1'b1;
                    sw[4] = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/id_ctrl_unit.sv
// Decode-stage control generator: instruction decode plus the load-use stall,
// branch-flush window and HLT/restart sequencing.
// Optional build macro ID_CTRL_PERF_EN adds a saturating 16-bit stall counter
// (stall_count) that counts every stalled cycle, including HALT.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal decode, load-use interlock active
// FLUSH | squash decode for flush_cnt+1 more cycles after a taken branch
// HALT  | HLT executed; hold PC/IF-ID until restart
module id_ctrl_unit
    import simple_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    input  logic        ex_memread,
    input  logic [2:0]  ex_rd,
    input  logic        branch_taken,
    input  logic        restart,
    output logic        sw1,
    output logic        sw2,
    output logic        sw3,
    output logic        sw4,
    output logic        sw5,
    output logic        sw6,
    output logic        sw7,
    output logic        writeOrder,
    output logic        stall,
    output logic        halted
`ifdef ID_CTRL_PERF_EN
    ,
    output logic [15:0] stall_count
`endif
);

    // FLUSH_CYCLES of 0 means a taken branch costs only its own bubble.
    localparam bit         FLUSH_EN   = (FLUSH_CYCLES > 0);
    localparam logic [1:0] FLUSH_LOAD = FLUSH_EN ? 2'(FLUSH_CYCLES - 1) : 2'd0;

    state_t     state, next_state;
    logic [1:0] flush_cnt, next_cnt;
    logic [6:0] dec_sw;
    logic       dec_wo;
    logic       dec_hlt;
    logic       hazard;
    logic       pass;
    logic       unused_imm;

    // The low nibble is immediate/register data, irrelevant to control.
    assign unused_imm = ^instr[3:0];

    id_decode u_decode (
        .major       (instr[15:14]),
        .sub         (instr[13:11]),
        .op3         (instr[7:4]),
        .sw          (dec_sw),
        .write_order (dec_wo),
        .is_hlt      (dec_hlt)
    );

    assign hazard = ex_memread && instr_valid &&
                    !is_hazard_exempt(instr[15:14], instr[13:11]) &&
                    ((ex_rd == instr[13:11]) || (ex_rd == instr[10:8]));

    // Interlock priority and next-state selection
    always_comb begin
        pass       = 1'b0;
        stall      = 1'b0;
        halted     = 1'b0;
        next_state = state;
        next_cnt   = flush_cnt;
        case (state)
            HALT: begin
                stall  = 1'b1;
                halted = 1'b1;
                if (restart) begin
                    next_state = RUN;
                end
            end
            FLUSH: begin
                if (branch_taken) begin
                    if (FLUSH_EN) begin
                        next_cnt = FLUSH_LOAD;
                    end else begin
                        next_state = RUN;
                    end
                end else if (flush_cnt == 2'd0) begin
                    next_state = RUN;
                end else begin
                    next_cnt = flush_cnt - 2'd1;
                end
            end
            default: begin
                if (branch_taken) begin
                    if (FLUSH_EN) begin
                        next_state = FLUSH;
                        next_cnt   = FLUSH_LOAD;
                    end
                end else if (hazard) begin
                    stall = 1'b1;
                end else if (instr_valid) begin
                    if (dec_hlt) begin
                        next_state = HALT;
                    end else begin
                        pass = 1'b1;
                    end
                end
            end
        endcase
    end

    assign sw1        = pass & dec_sw[0];
    assign sw2        = pass & dec_sw[1];
    assign sw3        = pass & dec_sw[2];
    assign sw4        = pass & dec_sw[3];
    assign sw5        = pass & dec_sw[4];
    assign sw6        = pass & dec_sw[5];
    assign sw7        = pass & dec_sw[6];
    assign writeOrder = pass & dec_wo;

    // State register and flush window counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            flush_cnt <= 2'd0;
        end else begin
            state     <= next_state;
            flush_cnt <= next_cnt;
        end
    end

`ifdef ID_CTRL_PERF_EN
    // Saturating count of stalled cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= 16'd0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
